// File: rtl/apb_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: turns each accepted AHB transfer into one
// APB SETUP/ACCESS pair and stretches the AHB data phase through Hready_out.
module apb_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [2:0]        tempselx,
  output logic [2:0]        Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hready_out
);

  typedef enum logic [1:0] {StIdle, StWwait, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        pselx_q, pselx_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              hready_q, hready_d;
  logic              accept;

  assign accept = valid && hready_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pselx_d   = pselx_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    hready_d  = hready_q;

    unique case (state_q)
      StIdle, StAccess: begin
        penable_d = 1'b0;
        if (accept && !Hwrite) begin
          state_d  = StSetup;
          paddr_d  = Haddr;
          pselx_d  = tempselx;
          pwrite_d = 1'b0;
          hready_d = 1'b0;
        end else if (accept) begin
          // Write data is not on the bus yet; wait one data-phase cycle for Hwdata.
          state_d  = StWwait;
          sel_d    = tempselx;
          pselx_d  = 3'b000;
          hready_d = 1'b0;
        end else begin
          state_d  = StIdle;
          pselx_d  = 3'b000;
          hready_d = 1'b1;
        end
      end
      StWwait: begin
        state_d  = StSetup;
        paddr_d  = Haddr1;
        pwdata_d = Hwdata;
        pselx_d  = sel_q;
        pwrite_d = 1'b1;
        hready_d = 1'b0;
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
        hready_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      hready_q  <= hready_d;
    end
  end

  assign Pselx      = pselx_q;
  assign Penable    = penable_q;
  assign Pwrite     = pwrite_q;
  assign Paddr      = paddr_q;
  assign Pwdata     = pwdata_q;
  assign Hready_out = hready_q;

endmodule

// File: doc/apb_controller.md
# apb_controller

APB-side sequencer of the AHB-to-APB bridge, directly downstream of the AHB slave interface. It takes that stage's decoded `valid`, `tempselx`, the raw and one-cycle-delayed address, and the write data. It then runs each accepted AHB transfer as one APB SETUP→ACCESS transaction and drives `Hready_out` to stretch the AHB data phase. It handles single and back-to-back reads and writes, with no PREADY or PSLVERR support.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports:
- `Hclk`  in  1  bridge clock; all state changes on rising edge
- `Hresetn`  in  1  asynchronous, active-low reset
- `valid`  in  1  AHB slave stage: current address phase targets the bridge (NONSEQ/SEQ, in range, Hready high)
- `Hwrite`  in  1  current address-phase direction
- `Haddr`  in  ADDR_W  current address-phase address
- `Haddr1`  in  ADDR_W  `Haddr` delayed one `Hclk`
- `Hwdata`  in  DATA_W  AHB write data bus
- `tempselx`  in  3  one-hot peripheral decode of `Haddr` (001/010/100)
- `Pselx`  out  3  APB one-hot select
- `Penable`  out  1  APB enable
- `Pwrite`  out  1  APB direction
- `Paddr`  out  ADDR_W  APB address
- `Pwdata`  out  DATA_W  APB write data
- `Hready_out`  out  1  to AHB; low stretches the current data phase

## Operation
- All outputs are registered. Each output's next value is a function of the state and inputs in the current cycle.
- Internal register `sel_q[2:0]` captures `tempselx` when a write is accepted.
- Accept condition: `valid && Hready_out`.
- States: IDLE, WWAIT, SETUP, ACCESS.
- IDLE: `Hready_out`=1, `Pselx`=0, `Penable`=0.
  - accept with `Hwrite`=0 → SETUP, loading `Paddr`←`Haddr`, `Pselx`←`tempselx`, `Pwrite`←0, `Hready_out`←0.
  - accept with `Hwrite`=1 → WWAIT, capturing `sel_q`←`tempselx`, `Hready_out`←0, `Pselx` stays 0.
  - no accept → stay in IDLE.
- WWAIT: the write data phase; `Hwdata` and `Haddr1` belong to the accepted write.
  - Always → SETUP, loading `Paddr`←`Haddr1`, `Pwdata`←`Hwdata`, `Pselx`←`sel_q`, `Pwrite`←1, `Hready_out` stays 0.
  - `valid` is ignored in this state.
- SETUP: `Pselx`≠0, `Penable`=0.
  - Always → ACCESS, with `Penable`←1, `Hready_out`←1.
  - `Paddr`, `Pwrite`, `Pwdata`, `Pselx` hold.
- ACCESS: `Penable`=1, `Hready_out`=1. This ends the AHB data phase: read data is forwarded combinationally upstream and is sampled by the master in this cycle.
  - accept read → SETUP, with a new `Paddr`/`Pselx` from `Haddr`/`tempselx`, `Pwrite`←0, `Penable`←0, `Hready_out`←0.
  - accept write → WWAIT, with `sel_q`←`tempselx`, `Pselx`←0, `Penable`←0, `Hready_out`←0.
  - no accept → IDLE, with `Pselx`←0, `Penable`←0, `Hready_out`←1.
- `Paddr`, `Pwdata`, `Pwrite` keep their last values when not selected. They are never cleared except by reset.
- `Pselx` is only ever 0 or a one-hot value. `valid` implies `tempselx`≠0.

## Timing
- Reset (async, immediate): state IDLE, `Pselx`=0, `Penable`=0, `Pwrite`=0, `Paddr`=0, `Pwdata`=0, `sel_q`=0, `Hready_out`=1.
- Reset asserted mid-transfer abandons that transfer. No APB completion is generated. Outputs return to reset values within the same cycle.
- Read, address accepted in cycle N:
  - SETUP in N+1, ACCESS in N+2.
  - `Hready_out`=0 in N+1, =1 in N+2.
  - 2-cycle data phase.
- Write, address accepted in cycle N:
  - WWAIT in N+1, SETUP in N+2, ACCESS in N+3.
  - `Hready_out` low in N+1 and N+2.
  - 3-cycle data phase; the master holds `Hwdata` throughout.
- Back-to-back read accepted in ACCESS: the next SETUP begins immediately, with no IDLE gap. This gives one APB read every 2 cycles.
- Write followed by anything: the next transfer is accepted in the write's ACCESS cycle.
- `Penable` is never high in a cycle where `Pselx`=0.

## Test plan
- Read 0x8000_0010 from IDLE in cycle 0:
  - cycle 1: `Pselx`=001, `Paddr`=0x8000_0010, `Pwrite`=0, `Penable`=0, `Hready_out`=0.
  - cycle 2: `Penable`=1, `Hready_out`=1.
  - cycle 3: `Pselx`=0.
- Write 0x8400_0004 with data 0xDEAD_BEEF in data phase:
  - cycle 1: `Pselx`=0, `Hready_out`=0.
  - cycle 2: `Pselx`=010, `Paddr`=0x8400_0004, `Pwdata`=0xDEAD_BEEF, `Pwrite`=1.
  - cycle 3: `Penable`=1.
- Three back-to-back reads at 0x8800_0000/04/08:
  - SETUP in cycles 1, 3, 5; ACCESS in cycles 2, 4, 6.
  - `Pselx`=100 continuously from cycle 1 to cycle 6.
- Write to 0x8000_0000, then a read at 0x8400_0000 presented and held:
  - read is accepted in the write's ACCESS (cycle 3).
  - read SETUP in cycle 4 with `Pselx`=010, `Pwrite`=0.
- `valid`=0 (IDLE/BUSY Htrans or out-of-range address) for 10 cycles: `Pselx`=0, `Penable`=0, `Hready_out`=1 throughout.
- `Hresetn` pulled low mid-cycle during SETUP of a write:
  - all outputs reach reset values immediately.
  - after release, a read behaves exactly as in the first scenario.
